// File: rtl/seven_seg_pkg.sv
// Shared constants and types for the seven-segment display blocks.
package seven_seg_pkg;

  localparam int PRESCALE_DEF  = 100000;
  localparam int BLANK_CYC_DEF = 64;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'hF;

  // Active-low glyphs {g,f,e,d,c,b,a}; entry 0 is the rightmost element.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

  // One complete display image: digits, decimal points and enables.
  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  en;
  } disp_cfg_t;

  localparam disp_cfg_t DISP_RESET = '{value: 16'h0000, dp: 4'h0, en: 4'hF};

endpackage

// File: rtl/hex_to_seg.sv
// Combinational nibble to active-low seven-segment decoder.
module hex_to_seg
  import seven_seg_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  assign seg_o = HEX_SEG[nib_i];

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Scan controller: generates the scan clock for the external digit counter,
// double-buffers display images with frame-synchronous commit, blanks the
// anodes after every digit change and applies PWM brightness.
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int PRESCALE  = PRESCALE_DEF,
  parameter int BLANK_CYC = BLANK_CYC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  digit_en,
  input  logic        load,
  input  logic [3:0]  brightness,
  input  logic [1:0]  digit_sel,
  output logic        scan_clk,
  output logic        pending,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int HALF = PRESCALE / 2;
  localparam int PW   = $clog2(HALF);
  localparam int BW   = $clog2(BLANK_CYC + 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(HALF - 1);
  localparam logic [BW-1:0] BLANK_LD = BW'(BLANK_CYC);

  logic [PW-1:0] presc_q;
  logic          scan_clk_q;
  logic [1:0]    sel_q;
  logic [BW-1:0] blank_q;
  logic [3:0]    duty_q;
  disp_cfg_t     pend_q;
  disp_cfg_t     act_q;
  logic          pend_flag_q;
  logic [3:0]    an_q;
  logic [6:0]    seg_q;
  logic          dp_q;

  logic          boundary;
  logic          pwm_on;
  logic          lit;
  logic [3:0]    nib_sel;
  logic [6:0]    seg_dec;

  assign boundary = (sel_q == 2'd3) && (digit_sel == 2'd0);
  assign pwm_on   = (brightness == 4'd15) || (duty_q < brightness);
  assign lit      = (blank_q == '0) && pwm_on && act_q.en[sel_q];
  assign nib_sel  = act_q.value[{sel_q, 2'b00} +: 4];

  hex_to_seg u_dec (
    .nib_i (nib_sel),
    .seg_o (seg_dec)
  );

  // Prescaler: half-period counter toggling the registered scan clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q    <= '0;
      scan_clk_q <= 1'b0;
    end else if (presc_q == PRE_LAST) begin
      presc_q    <= '0;
      scan_clk_q <= ~scan_clk_q;
    end else begin
      presc_q    <= presc_q + 1'b1;
    end
  end

  // Track the counter's digit select and arm anti-ghost blanking on change.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel_q   <= 2'd0;
      blank_q <= '0;
    end else begin
      sel_q <= digit_sel;
      if (digit_sel != sel_q) begin
        blank_q <= BLANK_LD;
      end else if (blank_q != '0) begin
        blank_q <= blank_q - 1'b1;
      end
    end
  end

  // Free-running PWM phase counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      duty_q <= 4'd0;
    end else begin
      duty_q <= duty_q + 4'd1;
    end
  end

  // Double buffer: load fills the pending image, the 3->0 frame boundary
  // promotes it; a load on the boundary edge queues behind the commit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q      <= '0;
      pend_flag_q <= 1'b0;
      act_q       <= DISP_RESET;
    end else begin
      if (boundary && pend_flag_q) begin
        act_q <= pend_q;
      end
      if (load) begin
        pend_q      <= '{value: value, dp: dp_in, en: digit_en};
        pend_flag_q <= 1'b1;
      end else if (boundary) begin
        pend_flag_q <= 1'b0;
      end
    end
  end

  // Registered display drive; everything dark when the digit is not lit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an_q  <= AN_OFF;
      seg_q <= SEG_BLANK;
      dp_q  <= 1'b1;
    end else if (lit) begin
      an_q  <= ~(4'b0001 << sel_q);
      seg_q <= seg_dec;
      dp_q  <= ~act_q.dp[sel_q];
    end else begin
      an_q  <= AN_OFF;
      seg_q <= SEG_BLANK;
      dp_q  <= 1'b1;
    end
  end

  assign scan_clk = scan_clk_q;
  assign pending  = pend_flag_q;
  assign an       = an_q;
  assign seg      = seg_q;
  assign dp       = dp_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Scoreboard bench for seven_seg_scan_ctrl with a 2-bit counter closing the
// scan loop through scan_clk.
module tb_seven_seg_scan_ctrl;

  localparam int PRESCALE  = 4;
  localparam int BLANK_CYC = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value = 16'h0;
  logic [3:0]  dp_in = 4'h0;
  logic [3:0]  digit_en = 4'hF;
  logic        load = 1'b0;
  logic [3:0]  brightness = 4'hF;
  logic [1:0]  digit_sel;
  logic        scan_clk;
  logic        pending;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  always #5 clk = ~clk;

  seven_seg_scan_ctrl #(.PRESCALE(PRESCALE), .BLANK_CYC(BLANK_CYC)) dut (
    .clk        (clk),
    .rst        (rst),
    .value      (value),
    .dp_in      (dp_in),
    .digit_en   (digit_en),
    .load       (load),
    .brightness (brightness),
    .digit_sel  (digit_sel),
    .scan_clk   (scan_clk),
    .pending    (pending),
    .an         (an),
    .seg        (seg),
    .dp         (dp)
  );

  // The 2-bit digit counter driven by the divided scan clock.
  always @(posedge scan_clk or negedge rst) begin
    if (!rst) digit_sel <= 2'd0;
    else      digit_sel <= digit_sel + 2'd1;
  end

  typedef struct packed {
    logic [15:0] v;
    logic [3:0]  d;
    logic [3:0]  e;
  } cfg_t;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } out_t;

  out_t expq[$];
  int   checks = 0;
  int   errors = 0;

  // Model state
  cfg_t       m_act, m_pend, prev_cfg, cur_cfg, bnd_cfg;
  bit         m_pflag, prev_ld, bnd_arm;
  logic [1:0] ds_h [4];
  int         n;
  logic [3:0] cur_b;

  // Per-scenario observation counters
  int lit_cnt, bad_an_cnt, dp_cnt, saw_a, saw_5;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  function automatic logic [6:0] glyph(input logic [3:0] x);
    case (x)
      4'h0: glyph = 7'h40;  4'h1: glyph = 7'h79;  4'h2: glyph = 7'h24;  4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;  4'h5: glyph = 7'h12;  4'h6: glyph = 7'h02;  4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;  4'h9: glyph = 7'h10;  4'hA: glyph = 7'h08;  4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;  4'hD: glyph = 7'h21;  4'hE: glyph = 7'h06;  default: glyph = 7'h0E;
    endcase
  endfunction

  task automatic model_reset();
    m_act   = '{v: 16'h0, d: 4'h0, e: 4'hF};
    m_pend  = '0;
    m_pflag = 1'b0;
    prev_ld = 1'b0;
    prev_cfg = '0;
    bnd_arm = 1'b0;
    for (int i = 0; i < 4; i++) ds_h[i] = 2'd0;
    n = 0;
    expq.delete();
  endtask

  // Record the select seen after this edge, predict the output of the next
  // edge, then drive the stimulus for that edge.
  task automatic plan(input bit ld, input cfg_t c, input logic [3:0] b);
    out_t       e;
    logic [1:0] s;
    bit         quiet, pwm, lit;
    ds_h[3] = ds_h[2];
    ds_h[2] = ds_h[1];
    ds_h[1] = ds_h[0];
    ds_h[0] = digit_sel;
    if (bnd_arm && ds_h[0] == 2'd0 && ds_h[1] == 2'd3) begin
      ld = 1'b1;
      c = bnd_cfg;
      bnd_arm = 1'b0;
    end
    s     = ds_h[1];
    quiet = (ds_h[1] == ds_h[2]) && (ds_h[2] == ds_h[3]);
    pwm   = (b == 4'd15) || ((n % 16) < int'(b));
    lit   = quiet && pwm && m_act.e[s];
    if (lit) begin
      e.an  = ~(4'b0001 << s);
      e.seg = glyph(m_act.v[4*s +: 4]);
      e.dp  = ~m_act.d[s];
    end else begin
      e.an  = 4'hF;
      e.seg = 7'h7F;
      e.dp  = 1'b1;
    end
    expq.push_back(e);
    load       = ld;
    value      = c.v;
    dp_in      = c.d;
    digit_en   = c.e;
    brightness = b;
    prev_ld    = ld;
    prev_cfg   = c;
  endtask

  task automatic step(input bit ld, input cfg_t c, input logic [3:0] b);
    out_t e;
    bit   bnd;
    @(negedge clk);
    n++;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      check("an", an, e.an);
      check("seg", seg, e.seg);
      check("dp", dp, e.dp);
    end else begin
      check("sb_underflow", 0, 1);
    end
    check("scan_clk", scan_clk, (n / 2) % 2);
    if (an != 4'hF) lit_cnt++;
    if (an[1] == 1'b0 || an[3] == 1'b0) bad_an_cnt++;
    if (dp == 1'b0) dp_cnt++;
    if (an != 4'hF && seg == 7'h08) saw_a++;
    if (an != 4'hF && seg == 7'h12) saw_5++;
    bnd = (ds_h[1] == 2'd3) && (ds_h[0] == 2'd0);
    if (bnd && m_pflag) m_act = m_pend;
    if (prev_ld) begin
      m_pend  = prev_cfg;
      m_pflag = 1'b1;
    end else if (bnd) begin
      m_pflag = 1'b0;
    end
    check("pending", pending, m_pflag);
    plan(ld, c, b);
  endtask

  task automatic run(input int k);
    repeat (k) step(1'b0, cur_cfg, cur_b);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] e);
    cfg_t c;
    c = '{v: v, d: d, e: e};
    step(1'b1, c, cur_b);
  endtask

  task automatic wait_sel(input logic [1:0] s);
    int k;
    k = 0;
    while (ds_h[0] != s && k < 64) begin
      run(1);
      k++;
    end
    if (ds_h[0] != s) check("wait_sel_timeout", ds_h[0], s);
  endtask

  task automatic clear_counts();
    lit_cnt = 0; bad_an_cnt = 0; dp_cnt = 0; saw_a = 0; saw_5 = 0;
  endtask

  task automatic start();
    rst = 1'b1;
    model_reset();
    plan(1'b0, cur_cfg, cur_b);
  endtask

  initial begin
    int k;
    cur_cfg = '{v: 16'h0, d: 4'h0, e: 4'hF};
    cur_b   = 4'd15;
    clear_counts();
    #1 rst = 1'b0;
    #3;
    check("rst_an", an, 4'hF);
    check("rst_seg", seg, 7'h7F);
    check("rst_dp", dp, 1'b1);
    check("rst_pending", pending, 1'b0);
    check("rst_scan_clk", scan_clk, 1'b0);
    repeat (2) @(negedge clk);
    start();

    // 1: free-running scan showing 0000 at full brightness
    clear_counts();
    run(40);
    check("s1_lit_seen", lit_cnt > 0, 1);

    // 2: mid-frame load of 1234
    wait_sel(2'd1);
    do_load(16'h1234, 4'h0, 4'hF);
    run(40);

    // 3: two loads before the boundary, last wins
    wait_sel(2'd1);
    clear_counts();
    do_load(16'hAAAA, 4'h0, 4'hF);
    run(2);
    do_load(16'h5555, 4'h0, 4'hF);
    run(40);
    check("s3_aaaa_never_shown", saw_a, 0);
    check("s3_5555_shown", saw_5 > 0, 1);

    // 4: load on the boundary edge while 0001 is pending
    wait_sel(2'd1);
    do_load(16'h0001, 4'h0, 4'hF);
    bnd_cfg = '{v: 16'hBEEF, d: 4'h0, e: 4'hF};
    bnd_arm = 1'b1;
    k = 0;
    while (bnd_arm && k < 40) begin
      run(1);
      k++;
    end
    check("s4_bnd_load_issued", bnd_arm, 1'b0);
    k = 0;
    for (int i = 0; i < 40; i++) begin
      run(1);
      if (pending) k++;
      else break;
    end
    check("s4_pending_frame_len", k, 16);
    run(20);

    // 5: brightness sweep
    cur_b = 4'd4;
    run(48);
    cur_b = 4'd0;
    run(2);
    clear_counts();
    run(32);
    check("s5_dark_at_zero", lit_cnt, 0);
    cur_b = 4'd15;
    run(32);

    // 6: partial enables and decimal points, then async reset mid-frame
    do_load(16'h89AB, 4'b0010, 4'b0101);
    run(40);
    clear_counts();
    run(32);
    check("s6_disabled_anodes", bad_an_cnt, 0);
    check("s6_dp_dark", dp_cnt, 0);
    check("s6_lit_seen", lit_cnt > 0, 1);
    do_load(16'h7777, 4'hF, 4'hF);
    k = 0;
    while (an == 4'hF && k < 32) begin
      run(1);
      k++;
    end
    check("s6_lit_before_reset", an != 4'hF, 1);
    #2 rst = 1'b0;
    load = 1'b0;
    #1;
    check("s6_rst_an", an, 4'hF);
    check("s6_rst_seg", seg, 7'h7F);
    check("s6_rst_dp", dp, 1'b1);
    check("s6_rst_pending", pending, 1'b0);
    check("s6_rst_scan_clk", scan_clk, 1'b0);
    repeat (3) @(negedge clk);
    cur_cfg = '{v: 16'h0, d: 4'h0, e: 4'hF};
    start();
    run(24);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
